// File: rtl/aer_pkg.sv
// AER link definitions shared by the spike serializer and the receive-side deserializer.
package aer_pkg;

  localparam int AER_ADDR_W = 12;
  localparam int AER_IDX_W  = 10;

  localparam logic [1:0] AER_SPIKE = 2'b00;
  localparam logic [1:0] AER_TSTEP = 2'b01;

  function automatic logic [1:0] aer_type(input logic [AER_ADDR_W-1:0] addr);
    return addr[AER_ADDR_W-1 -: 2];
  endfunction

  function automatic logic [AER_IDX_W-1:0] aer_idx(input logic [AER_ADDR_W-1:0] addr);
    return addr[AER_IDX_W-1:0];
  endfunction

  function automatic logic [AER_ADDR_W-1:0] aer_pack(input logic [1:0] typ,
                                                     input logic [AER_IDX_W-1:0] idx);
    return {typ, idx};
  endfunction

endpackage

// File: rtl/aer_to_parallel.sv
// AER receiver: 4-phase REQ/ACK handshake, rebuilds each timestep's spike bitmap
// into DATA_WIDTH-bit words on a valid/ready stream, pulses finish every STEP timesteps.
module aer_to_parallel
  import aer_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_MAX    = 783,
  parameter int STEP       = 16
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  AER_IN_REQ,
  input  logic [AER_ADDR_W-1:0] AER_IN_ADDR,
  output logic                  AER_IN_ACK,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  finish,
  output logic                  err
);

  localparam int WORDS = (CNT_MAX + 1) / DATA_WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int TS_W  = (STEP > 1) ? $clog2(STEP) : 1;

  localparam logic [IDX_W-1:0]     LAST      = IDX_W'(WORDS - 1);
  localparam logic [TS_W-1:0]      TS_LAST   = TS_W'(STEP - 1);
  localparam logic [AER_IDX_W-1:0] DW_L      = AER_IDX_W'(DATA_WIDTH);
  localparam logic [31:0]          CNT_MAX_U = 32'(CNT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_ACK} state_t;

  state_t                  state;
  logic [AER_ADDR_W-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   word_buf;
  logic [IDX_W-1:0]        word_idx;
  logic [TS_W-1:0]         tstep_cnt;
  logic                    wrap_q;

  logic [1:0]              ev_type;
  logic [AER_IDX_W-1:0]    ev_idx;
  logic [AER_IDX_W-1:0]    target;
  logic [AER_IDX_W-1:0]    bit_pos;
  logic [AER_IDX_W-1:0]    idx_ext;
  logic [DATA_WIDTH-1:0]   bit_mask;
  logic                    out_range;

  // Event decode works off the latched address only, so no input reaches an output.
  always_comb begin
    ev_type   = aer_type(addr_q);
    ev_idx    = aer_idx(addr_q);
    target    = ev_idx / DW_L;
    bit_pos   = ev_idx % DW_L;
    idx_ext   = AER_IDX_W'(word_idx);
    bit_mask  = DATA_WIDTH'(1) << (DW_L - AER_IDX_W'(1) - bit_pos);
    out_range = 32'(ev_idx) > CNT_MAX_U;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      word_buf   <= '0;
      word_idx   <= '0;
      tstep_cnt  <= '0;
      wrap_q     <= 1'b0;
      AER_IN_ACK <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      finish     <= 1'b0;
      err        <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state)
        S_IDLE: begin
          if (AER_IN_REQ) begin
            addr_q <= AER_IN_ADDR;
            state  <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          if (ev_type == AER_TSTEP) begin
            if (!dout_valid) begin
              dout       <= word_buf;
              dout_last  <= (word_idx == LAST);
              dout_valid <= 1'b1;
            end else if (dout_ready) begin
              if (dout_last) begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
                word_idx   <= '0;
                word_buf   <= '0;
                if (tstep_cnt == TS_LAST) begin
                  tstep_cnt <= '0;
                  wrap_q    <= 1'b1;
                end else begin
                  tstep_cnt <= tstep_cnt + 1'b1;
                end
                state <= S_ACK;
              end else begin
                // Words after the first are untouched by this timestep, so they are zero.
                dout      <= '0;
                dout_last <= ((word_idx + 1'b1) == LAST);
                word_idx  <= word_idx + 1'b1;
                word_buf  <= '0;
              end
            end
          end else if (ev_type == AER_SPIKE) begin
            if (!dout_valid) begin
              if (out_range || (target < idx_ext)) begin
                err   <= 1'b1;
                state <= S_ACK;
              end else if (target == idx_ext) begin
                word_buf <= word_buf | bit_mask;
                state    <= S_ACK;
              end else begin
                dout       <= word_buf;
                dout_last  <= (word_idx == LAST);
                dout_valid <= 1'b1;
              end
            end else if (dout_ready) begin
              word_idx <= word_idx + 1'b1;
              if (target == (idx_ext + 1'b1)) begin
                // Reached the spike's word: it starts out holding just this bit.
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
                word_buf   <= bit_mask;
                state      <= S_ACK;
              end else begin
                dout      <= '0;
                dout_last <= ((word_idx + 1'b1) == LAST);
                word_buf  <= '0;
              end
            end
          end else begin
            err   <= 1'b1;
            state <= S_ACK;
          end
        end

        S_ACK: begin
          if (AER_IN_REQ) begin
            AER_IN_ACK <= 1'b1;
          end else begin
            AER_IN_ACK <= 1'b0;
            finish     <= wrap_q;
            wrap_q     <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aer_to_parallel.sv
// Bench for aer_to_parallel: directed vector table, reset/finish corner sequences,
// and randomized timesteps checked against a bitmap-level reference model.
module tb_aer_to_parallel;
  import aer_pkg::*;

  localparam int DW      = 4;
  localparam int CNT_MAX = 783;
  localparam int STEP    = 16;
  localparam int WORDS   = (CNT_MAX + 1) / DW;
  localparam int BOUND   = 5000;
  localparam logic [11:0] MARK = 12'h400;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic          AER_IN_REQ = 1'b0;
  logic [11:0]   AER_IN_ADDR = '0;
  logic          AER_IN_ACK;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          dout_last;
  logic          finish;
  logic          err;

  int checks = 0;
  int errors = 0;
  bit ready_mode = 1'b0;

  typedef struct packed {logic [DW-1:0] d; logic l;} wrd_t;
  wrd_t got[$];

  int            finish_cnt = 0;
  bit            fin_wide = 1'b0;
  bit            prev_fin = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_l;

  // Reference model: the timestep's accepted spikes as a flat bitmap.
  bit bm[WORDS*DW];
  int cur_w = 0;
  bit m_err = 1'b0;

  typedef struct {
    logic [11:0] addr;
    logic        exp_err;
    bit          rnd_ready;
    bit          hold;
  } vec_t;
  vec_t tbl[12];

  always #5 CLK = ~CLK;

  aer_to_parallel #(.DATA_WIDTH(DW), .CNT_MAX(CNT_MAX), .STEP(STEP)) dut (
    .CLK(CLK), .rst_n(rst_n), .AER_IN_REQ(AER_IN_REQ), .AER_IN_ADDR(AER_IN_ADDR),
    .AER_IN_ACK(AER_IN_ACK), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .finish(finish), .err(err)
  );

  always @(posedge CLK) begin
    #1;
    dout_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge CLK) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_fin   = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!dout_valid || dout !== prev_d || dout_last !== prev_l) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%h l=%0b expected v=1 d=%h l=%0b",
                   dout_valid, dout, dout_last, prev_d, prev_l);
        end
      end
      if (dout_valid && dout_ready) got.push_back({dout, dout_last});
      prev_stall = dout_valid && !dout_ready;
      prev_d = dout;
      prev_l = dout_last;
      if (finish) finish_cnt++;
      if (finish && prev_fin) fin_wide = 1'b1;
      prev_fin = finish;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] spk(input int n);
    return aer_pack(AER_SPIKE, 10'(n));
  endfunction

  task automatic model_clear();
    foreach (bm[i]) bm[i] = 1'b0;
    cur_w = 0;
  endtask

  task automatic model_apply(input logic [11:0] a);
    int n;
    n = int'(a[9:0]);
    if (a[11]) m_err = 1'b1;
    else if (a[11:10] == AER_SPIKE) begin
      if (n > CNT_MAX || n / DW < cur_w) m_err = 1'b1;
      else begin
        bm[n] = 1'b1;
        cur_w = n / DW;
      end
    end
  endtask

  task automatic compare_ts(input string nm);
    logic [DW-1:0] e;
    chk({nm, "_count"}, got.size(), WORDS);
    for (int w = 0; w < WORDS && w < got.size(); w++) begin
      for (int j = 0; j < DW; j++) e[DW-1-j] = bm[DW*w+j];
      chk($sformatf("%s_w%0d", nm, w), {28'd0, got[w].d}, {28'd0, e});
      chk($sformatf("%s_last%0d", nm, w), {31'd0, got[w].l}, {31'd0, (w == WORDS-1)});
    end
  endtask

  task automatic send_event(input logic [11:0] a, input bit hold);
    int n;
    @(posedge CLK); #1;
    AER_IN_ADDR = a;
    AER_IN_REQ  = 1'b1;
    n = 0;
    while (!AER_IN_ACK && n < BOUND) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("ack_rise", {31'd0, AER_IN_ACK}, 32'd1);
    if (hold) begin
      repeat (3) @(posedge CLK);
      #1;
      chk("ack_hold_while_req", {31'd0, AER_IN_ACK}, 32'd1);
    end
    AER_IN_REQ = 1'b0;
    n = 0;
    while (AER_IN_ACK && n < 8) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("ack_fall", {31'd0, AER_IN_ACK}, 32'd0);
  endtask

  task automatic run_event(input logic [11:0] a, input bit hold, input string nm);
    model_apply(a);
    send_event(a, hold);
    chk({nm, "_err"}, {31'd0, err}, {31'd0, m_err});
    if (a[11:10] == AER_TSTEP) begin
      compare_ts(nm);
      got.delete();
      model_clear();
    end
  endtask

  task automatic check_outputs_zero(input string nm);
    chk({nm, "_ack"},   {31'd0, AER_IN_ACK}, 32'd0);
    chk({nm, "_dout"},  {28'd0, dout},       32'd0);
    chk({nm, "_valid"}, {31'd0, dout_valid}, 32'd0);
    chk({nm, "_last"},  {31'd0, dout_last},  32'd0);
    chk({nm, "_fin"},   {31'd0, finish},     32'd0);
    chk({nm, "_err"},   {31'd0, err},        32'd0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #2;
    rst_n = 1'b0;
    AER_IN_REQ = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    rst_n = 1'b1;
    got.delete();
    model_clear();
    m_err = 1'b0;
  endtask

  initial begin
    int n, lastn, k;
    logic [11:0] a;

    tbl[0]  = '{spk(0),   1'b0, 1'b0, 1'b0};
    tbl[1]  = '{spk(5),   1'b0, 1'b0, 1'b0};
    tbl[2]  = '{spk(6),   1'b0, 1'b0, 1'b0};
    tbl[3]  = '{MARK,     1'b0, 1'b0, 1'b0};
    tbl[4]  = '{MARK,     1'b0, 1'b1, 1'b0};
    tbl[5]  = '{spk(783), 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{MARK,     1'b0, 1'b1, 1'b1};
    tbl[7]  = '{spk(8),   1'b0, 1'b0, 1'b0};
    tbl[8]  = '{spk(3),   1'b1, 1'b0, 1'b0};
    tbl[9]  = '{12'h801,  1'b1, 1'b0, 1'b0};
    tbl[10] = '{spk(784), 1'b1, 1'b0, 1'b0};
    tbl[11] = '{MARK,     1'b1, 1'b0, 1'b0};

    #1;
    check_outputs_zero("reset");
    repeat (2) @(posedge CLK);
    #3;
    rst_n = 1'b1;
    model_clear();

    for (int i = 0; i < 12; i++) begin
      ready_mode = tbl[i].rnd_ready;
      model_apply(tbl[i].addr);
      send_event(tbl[i].addr, tbl[i].hold);
      chk($sformatf("tbl%0d_err", i), {31'd0, err}, {31'd0, tbl[i].exp_err});
      if (tbl[i].addr[11:10] == AER_TSTEP) begin
        if (i == 3 && got.size() >= 2) begin
          chk("tbl_word0", {28'd0, got[0].d}, 32'h8);
          chk("tbl_word1", {28'd0, got[1].d}, 32'h6);
        end
        if (i == 6 && got.size() == WORDS)
          chk("tbl_word195", {28'd0, got[WORDS-1].d}, 32'h1);
        if (i == 11 && got.size() >= 3)
          chk("tbl_word2", {28'd0, got[2].d}, 32'h8);
        compare_ts($sformatf("tbl%0d", i));
        got.delete();
        model_clear();
      end
    end
    ready_mode = 1'b0;

    // Four markers so far; twelve more land on the wrap.
    for (int i = 0; i < 12; i++) begin
      if (i == 11) begin
        repeat (3) @(posedge CLK);
        chk("finish_before_16th", finish_cnt, 0);
      end
      run_event(MARK, 1'b0, $sformatf("mk%0d", i));
    end
    repeat (3) @(posedge CLK);
    chk("finish_once", finish_cnt, 1);
    chk("finish_width", {31'd0, fin_wide}, 32'd0);

    // Reset in the middle of a marker flush.
    @(posedge CLK); #1;
    AER_IN_ADDR = MARK;
    AER_IN_REQ  = 1'b1;
    n = 0;
    while (got.size() < 100 && n < BOUND) begin
      @(negedge CLK);
      n++;
    end
    chk("midflush_reached", {31'd0, got.size() >= 100}, 32'd1);
    #1;
    rst_n = 1'b0;
    AER_IN_REQ = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(posedge CLK);
    #3;
    rst_n = 1'b1;
    got.delete();
    model_clear();
    m_err = 1'b0;
    repeat (3) @(posedge CLK);
    chk("midreset_no_finish", finish_cnt, 1);
    run_event(MARK, 1'b0, "post_reset");

    // Randomized timesteps against the model.
    do_reset();
    chk("rand_err_clear", {31'd0, err}, 32'd0);
    ready_mode = 1'b1;
    for (int t = 0; t < 8; t++) begin
      k = $urandom_range(0, 12);
      lastn = 0;
      for (int e = 0; e < k; e++) begin
        case ($urandom_range(0, 19))
          0:       a = 12'h800 | 12'($urandom_range(0, 1023));
          1, 2:    a = spk($urandom_range(0, 1023));
          default: begin
            n = lastn + $urandom_range(0, 120);
            if (n > CNT_MAX) n = CNT_MAX;
            lastn = n;
            a = spk(n);
          end
        endcase
        run_event(a, 1'b0, $sformatf("r%0d_%0d", t, e));
      end
      run_event(MARK, 1'b0, $sformatf("rts%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
